// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the cipher datapath.
package aes_pkg;

    localparam logic [7:0] GF_POLY      = 8'h1B;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: inverse affine, then GF(2^8) inversion
// computed as x^254 (which also maps 0 to 0).
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] t;
    logic [7:0] x3, x7, x15, x31, x63, x127;

    always_comb begin
        t = {in_byte[6:0], in_byte[7]}
          ^ {in_byte[4:0], in_byte[7:5]}
          ^ {in_byte[1:0], in_byte[7:2]}
          ^ INV_AFFINE_C;
    end

    // Addition chain: x^(2^k - 1) = (x^(2^(k-1) - 1))^2 * x, ending in x^254 = (x^127)^2.
    always_comb begin
        x3       = gf_mul(gf_mul(t, t), t);
        x7       = gf_mul(gf_mul(x3, x3), t);
        x15      = gf_mul(gf_mul(x7, x7), t);
        x31      = gf_mul(gf_mul(x15, x15), t);
        x63      = gf_mul(gf_mul(x31, x31), t);
        x127     = gf_mul(gf_mul(x63, x63), t);
        out_byte = gf_mul(x127, x127);
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes engine: LANES inverse S-boxes sweep the 16-byte state
// over 16/LANES cycles between a valid/ready input and output handshake.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    input  logic         abort,
    output logic         busy
);

    localparam int unsigned N     = 16 / LANES;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    fsm_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       st_q, st_d;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_in[i] = st_q[4'(32'(cnt_q) * LANES + i)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .in_byte  (lane_in[g]),
            .out_byte (lane_out[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        unique case (state_q)
            IDLE: begin
                if (!abort && in_valid) begin
                    st_d    = in_state;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    st_d[4'(32'(cnt_q) * LANES + i)] = lane_out[i];
                end
                if (cnt_q == CNT_W'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition but keeps the partially processed data.
        if (abort) begin
            st_d    = (state_q == BUSY) ? st_q : st_d;
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = st_q;

endmodule
